// File: rtl/word_sequencer.sv
// Purpose : queues 2-bit words and plays them one by one into a sendword
//           instance (enable pulse, held word, ack wait, fixed inter-word gap).
// Latency : first enable 2 cycles after start; PULSE_CYCLES high, then ack wait and GAP_CYCLES gap.
// Backpressure: none upstream; writes while full are dropped and flagged.
// Ports:
//   sysclk, reset        clock, synchronous active-high reset
//   wr_en, wr_word       push a word into the queue
//   start, abort         begin draining / stop and flush
//   full, count, busy    queue and activity status
//   done, overflow, error  completion pulse, sticky drop flag, sticky ack timeout
//   sw_enable, sw_word, sw_status  sendword handshake
module word_sequencer #(
  parameter int DEPTH        = 8,
  parameter int PULSE_CYCLES = 100,
  parameter int ACK_TIMEOUT  = 1000,
  parameter int GAP_CYCLES   = 50000
) (
  input  logic                       sysclk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [1:0]                 wr_word,
  input  logic                       start,
  input  logic                       abort,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic                       error,
  output logic                       sw_enable,
  output logic [1:0]                 sw_word,
  input  logic                       sw_status
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] ACK_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] CNT_FULL   = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_DONE, GAP} state_t;

  state_t          state, state_nxt;
  logic            run, run_nxt;
  logic [1:0]      mem [DEPTH];
  logic [AW-1:0]   rd_ptr, rd_ptr_nxt, wr_ptr, wr_ptr_nxt;
  logic [CW-1:0]   count_nxt;
  logic [PW-1:0]   pulse_cnt, pulse_cnt_nxt;
  logic [TW-1:0]   ack_cnt, ack_cnt_nxt;
  logic [GW-1:0]   gap_cnt, gap_cnt_nxt;
  logic            ack_seen, ack_seen_nxt;
  logic            sw_enable_nxt, done_nxt, overflow_nxt, error_nxt;
  logic [1:0]      sw_word_nxt;
  logic            push, pop, flush;

  assign full = (count == CNT_FULL);
  assign busy = (state != IDLE) || run;

  always_comb begin
    state_nxt     = state;
    run_nxt       = run;
    rd_ptr_nxt    = rd_ptr;
    wr_ptr_nxt    = wr_ptr;
    count_nxt     = count;
    pulse_cnt_nxt = pulse_cnt;
    ack_cnt_nxt   = ack_cnt;
    gap_cnt_nxt   = gap_cnt;
    ack_seen_nxt  = ack_seen;
    sw_enable_nxt = sw_enable;
    sw_word_nxt   = sw_word;
    done_nxt      = 1'b0;
    overflow_nxt  = overflow;
    error_nxt     = error;
    push          = 1'b0;
    pop           = 1'b0;
    flush         = 1'b0;

    // run==0 implies IDLE, so a start can only ever launch a fresh drain
    if (start && !run) begin
      run_nxt      = 1'b1;
      error_nxt    = 1'b0;
      overflow_nxt = 1'b0;
    end

    if (wr_en) begin
      if (full) overflow_nxt = 1'b1;
      else      push         = 1'b1;
    end

    case (state)
      IDLE: begin
        if (run) begin
          if (count != '0) begin
            pop           = 1'b1;
            sw_word_nxt   = mem[rd_ptr];
            sw_enable_nxt = 1'b1;
            pulse_cnt_nxt = '0;
            ack_cnt_nxt   = '0;
            ack_seen_nxt  = 1'b0;
            state_nxt     = PULSE;
          end else begin
            run_nxt = 1'b0;
          end
        end
      end

      PULSE, WAIT_DONE: begin
        if (sw_status) ack_seen_nxt = 1'b1;

        if (state == PULSE) begin
          if (pulse_cnt == PULSE_LAST) begin
            sw_enable_nxt = 1'b0;
            state_nxt     = WAIT_DONE;
          end else begin
            pulse_cnt_nxt = pulse_cnt + PW'(1);
          end
        end else if (ack_seen && !sw_status) begin
          gap_cnt_nxt = '0;
          state_nxt   = GAP;
        end

        // Ack timer runs from the first enable-high cycle until status is seen;
        // hitting its terminal count abandons the whole queue.
        if (!ack_seen && !sw_status) begin
          if (ack_cnt == ACK_LAST) begin
            error_nxt     = 1'b1;
            sw_enable_nxt = 1'b0;
            sw_word_nxt   = 2'b00;
            run_nxt       = 1'b0;
            flush         = 1'b1;
            state_nxt     = IDLE;
          end else begin
            ack_cnt_nxt = ack_cnt + TW'(1);
          end
        end
      end

      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt   = IDLE;
          sw_word_nxt = 2'b00;
          if (count == '0) begin
            done_nxt = 1'b1;
            run_nxt  = 1'b0;
          end
        end else begin
          gap_cnt_nxt = gap_cnt + GW'(1);
        end
      end

      default: state_nxt = IDLE;
    endcase

    // abort overrides everything, including start and writes in the same cycle
    if (abort) begin
      state_nxt     = IDLE;
      run_nxt       = 1'b0;
      sw_enable_nxt = 1'b0;
      sw_word_nxt   = 2'b00;
      done_nxt      = 1'b0;
      overflow_nxt  = overflow;
      error_nxt     = error;
      flush         = 1'b1;
    end

    if (flush) begin
      push       = 1'b0;
      pop        = 1'b0;
      rd_ptr_nxt = '0;
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + AW'(1);
      if (pop)  rd_ptr_nxt = rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_nxt = count + CW'(1);
        2'b01:   count_nxt = count - CW'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= IDLE;
      run       <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      pulse_cnt <= '0;
      ack_cnt   <= '0;
      gap_cnt   <= '0;
      ack_seen  <= 1'b0;
      sw_enable <= 1'b0;
      sw_word   <= 2'b00;
      done      <= 1'b0;
      overflow  <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      run       <= run_nxt;
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      count     <= count_nxt;
      pulse_cnt <= pulse_cnt_nxt;
      ack_cnt   <= ack_cnt_nxt;
      gap_cnt   <= gap_cnt_nxt;
      ack_seen  <= ack_seen_nxt;
      sw_enable <= sw_enable_nxt;
      sw_word   <= sw_word_nxt;
      done      <= done_nxt;
      overflow  <= overflow_nxt;
      error     <= error_nxt;
    end
  end

  // Storage needs no reset; occupancy is tracked by count and the pointers.
  always_ff @(posedge sysclk) begin
    if (push && !reset) mem[wr_ptr] <= wr_word;
  end

endmodule
